spi_core: RTL and testbench

Single-master SPI peripheral that sits in one I/O slot behind the slot-decoding I/O controller. It responds to the per-slot chip select, read/write strobes, 5-bit register address and 32-bit data buses. It also runs a byte-wide full-duplex SPI transfer engine with programmable clock divisor, CPOL and CPHA, plus eight active-low slave-select lines. Software sets CTRL and SS, writes a byte, then polls the ready bit (or waits for the interrupt) and reads the received byte.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_core_if.sv | 13 +
 rtl/spi_engine.sv | 118 +++++++++++
 rtl/spi_core.sv | 133 +++++++++++++
 tb/tb_spi_core.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI peripheral: register indices, CTRL field
// positions and the transfer FSM state encoding.
package spi_pkg;

  localparam logic [4:0] SPI_REG_RX   = 5'd0;
  localparam logic [4:0] SPI_REG_SS   = 5'd1;
  localparam logic [4:0] SPI_REG_TX   = 5'd2;
  localparam logic [4:0] SPI_REG_CTRL = 5'd3;
  localparam logic [4:0] SPI_REG_IRQ  = 5'd4;

  localparam int CTRL_DVSR_LSB = 0;
  localparam int CTRL_DVSR_MSB = 15;
  localparam int CTRL_CPOL_BIT = 16;
  localparam int CTRL_CPHA_BIT = 17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DLY,
    ST_P0,
    ST_P1
  } spi_state_t;

endpackage

// File: rtl/spi_core_if.sv
// Slot-level register bus between the I/O controller (master) and a peripheral (slave).
// Single-cycle writes, combinational read data; no backpressure on this bus.
interface spi_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/spi_engine.sv
// Byte-wide full-duplex SPI shifter with CPOL/CPHA; ready rises 16 or 17 half-periods after start.
// start is only honoured while ready=1; done pulses for one cycle on the completing edge.
module spi_engine
  import spi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  tx_byte,
  input  logic [15:0] dvsr,
  input  logic        cpol,
  input  logic        cpha,
  input  logic        live_cpol,
  input  logic        live_cpha,
  input  logic        miso,
  output logic        ready,
  output logic        done,
  output logic [7:0]  rx_byte,
  output logic        sclk,
  output logic        mosi
);

  spi_state_t  state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  tx_sreg, tx_sreg_nxt;
  logic [7:0]  rx_sreg, rx_sreg_nxt;
  logic [7:0]  rx_byte_nxt;
  logic        sclk_nxt;
  logic        half_end;

  assign half_end = (cnt == dvsr);
  assign ready    = (state == ST_IDLE);
  assign mosi     = (state != ST_IDLE) & tx_sreg[7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      tx_sreg <= '0;
      rx_sreg <= '0;
      rx_byte <= '0;
      sclk    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx_sreg <= tx_sreg_nxt;
      rx_sreg <= rx_sreg_nxt;
      rx_byte <= rx_byte_nxt;
      sclk    <= sclk_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    tx_sreg_nxt = tx_sreg;
    rx_sreg_nxt = rx_sreg;
    rx_byte_nxt = rx_byte;
    done        = 1'b0;
    sclk_nxt    = live_cpol;

    case (state)
      ST_IDLE: begin
        // The latched config is not yet valid on this edge, so use the live CPHA.
        if (start) begin
          tx_sreg_nxt = tx_byte;
          cnt_nxt     = '0;
          bit_cnt_nxt = '0;
          state_nxt   = live_cpha ? ST_DLY : ST_P0;
        end
      end
      ST_DLY: begin
        if (half_end) begin
          cnt_nxt   = '0;
          state_nxt = ST_P0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ST_P0: begin
        if (half_end) begin
          rx_sreg_nxt = {rx_sreg[6:0], miso};
          cnt_nxt     = '0;
          state_nxt   = ST_P1;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ST_P1: begin
        if (half_end) begin
          cnt_nxt = '0;
          if (bit_cnt == 3'd7) begin
            rx_byte_nxt = rx_sreg;
            done        = 1'b1;
            state_nxt   = ST_IDLE;
          end else begin
            tx_sreg_nxt = {tx_sreg[6:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 3'd1;
            state_nxt   = ST_P0;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // sclk is computed from the next state so the register lines up with it.
    if (state != ST_IDLE && state_nxt != ST_IDLE) begin
      sclk_nxt = cpol ^ (((state_nxt == ST_P1) & ~cpha) | ((state_nxt == ST_P0) & cpha));
    end
  end

endmodule

// File: rtl/spi_core.sv
// SPI master slot peripheral: register file, bus decode and optional IRQ (SPI_IRQ_EN).
// Writes take effect on the next edge, reads are combinational; TX writes are dropped while busy.
module spi_core
  import spi_pkg::*;
#(
  parameter int SS_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  spi_core_if.slave       bus,
  output logic            spi_sclk,
  output logic            spi_mosi,
  input  logic            spi_miso,
  output logic [SS_W-1:0] spi_ss_n,
  output logic            irq
);

  logic [SS_W-1:0] ss_reg;
  logic [15:0]     ctrl_dvsr;
  logic            ctrl_cpol;
  logic            ctrl_cpha;
  logic [15:0]     lat_dvsr;
  logic            lat_cpol;
  logic            lat_cpha;

  logic            wr_en;
  logic            start;
  logic            ready;
  logic            xfer_done;
  logic [7:0]      rx_byte;
  logic [31:0]     irq_rd;
  logic [31:0]     rd_mux;
  logic            unused_bits;

  assign wr_en    = bus.cs & bus.write;
  assign start    = wr_en & (bus.addr == SPI_REG_TX) & ready;
  assign spi_ss_n = ss_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_reg    <= '1;
      ctrl_dvsr <= '0;
      ctrl_cpol <= 1'b0;
      ctrl_cpha <= 1'b0;
      lat_dvsr  <= '0;
      lat_cpol  <= 1'b0;
      lat_cpha  <= 1'b0;
    end else begin
      if (wr_en && bus.addr == SPI_REG_SS) begin
        ss_reg <= bus.wr_data[SS_W-1:0];
      end
      if (wr_en && bus.addr == SPI_REG_CTRL) begin
        ctrl_dvsr <= bus.wr_data[CTRL_DVSR_MSB:CTRL_DVSR_LSB];
        ctrl_cpol <= bus.wr_data[CTRL_CPOL_BIT];
        ctrl_cpha <= bus.wr_data[CTRL_CPHA_BIT];
      end
      // Freeze timing for the whole transfer; later CTRL writes apply to the next one.
      if (start) begin
        lat_dvsr <= ctrl_dvsr;
        lat_cpol <= ctrl_cpol;
        lat_cpha <= ctrl_cpha;
      end
    end
  end

  spi_engine u_engine (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .tx_byte   (bus.wr_data[7:0]),
    .dvsr      (lat_dvsr),
    .cpol      (lat_cpol),
    .cpha      (lat_cpha),
    .live_cpol (ctrl_cpol),
    .live_cpha (ctrl_cpha),
    .miso      (spi_miso),
    .ready     (ready),
    .done      (xfer_done),
    .rx_byte   (rx_byte),
    .sclk      (spi_sclk),
    .mosi      (spi_mosi)
  );

`ifdef SPI_IRQ_EN
  logic irq_ie;
  logic irq_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_ie   <= 1'b0;
      irq_done <= 1'b0;
    end else begin
      if (wr_en && bus.addr == SPI_REG_IRQ) begin
        irq_ie <= bus.wr_data[0];
        if (bus.wr_data[1]) begin
          irq_done <= 1'b0;
        end
      end
      // Placed after the clear so a completion on the same edge is never lost.
      if (xfer_done) begin
        irq_done <= 1'b1;
      end
    end
  end

  assign irq    = irq_done & irq_ie;
  assign irq_rd = {30'b0, irq_done, irq_ie};
`else
  assign irq    = 1'b0;
  assign irq_rd = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      SPI_REG_RX:   rd_mux = {23'b0, ready, rx_byte};
      SPI_REG_SS:   rd_mux[SS_W-1:0] = ss_reg;
      SPI_REG_CTRL: begin
        rd_mux[CTRL_DVSR_MSB:CTRL_DVSR_LSB] = ctrl_dvsr;
        rd_mux[CTRL_CPOL_BIT]               = ctrl_cpol;
        rd_mux[CTRL_CPHA_BIT]               = ctrl_cpha;
      end
      SPI_REG_IRQ:  rd_mux = irq_rd;
      default:      rd_mux = '0;
    endcase
  end

  assign bus.rd_data = rd_mux;

  // Reads are side-effect free, so the read strobe is intentionally not decoded.
  assign unused_bits = &{1'b0, bus.read, bus.wr_data, xfer_done};

endmodule

// File: tb/tb_spi_core.sv
// Directed bench for spi_core: reset, SPI modes 0/3, busy-write rejection, CTRL latching, IRQ.
module tb_spi_core;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic [7:0] spi_ss_n;
  logic       irq;

  logic       loop_en = 1'b0;
  logic       slv_en = 1'b0;
  logic [7:0] slv_byte = 8'h00;
  logic [2:0] slv_ptr = 3'd0;
  logic       cap_en = 1'b0;
  logic [7:0] cap = 8'h00;
  int         cap_n = 0;

  int vectors = 0;
  int miscompares = 0;

  spi_core_if bus ();

  spi_core #(.SS_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_ss_n (spi_ss_n),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  assign spi_miso = loop_en ? spi_mosi : slv_byte[slv_ptr];

  // Slave shifts on the falling edge: pointer walks 7..0 and wraps after a byte.
  always @(negedge spi_sclk) if (slv_en) slv_ptr = slv_ptr - 3'd1;

  always @(posedge spi_sclk) if (cap_en) begin
    cap = {cap[6:0], spi_mosi};
    cap_n++;
  end

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.write = 1'b0; bus.addr = SPI_REG_RX; bus.wr_data = '0;
    #1;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.read = 1'b1; bus.addr = a;
    #1;
    d = bus.rd_data;
    bus.cs = 1'b0; bus.read = 1'b0; bus.addr = SPI_REG_RX;
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.rd_data[8] !== 1'b1 && n < 4000) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (spi_ss_n !== 8'hFF) begin miscompares++; $display("FAIL reset_ss: got %h expected ff", spi_ss_n); end
    vectors++; if (spi_sclk !== 1'b0) begin miscompares++; $display("FAIL reset_sclk: got %b expected 0", spi_sclk); end
    vectors++; if (spi_mosi !== 1'b0) begin miscompares++; $display("FAIL reset_mosi: got %b expected 0", spi_mosi); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b expected 0", irq); end
    vectors++; if (bus.rd_data !== 32'h100) begin miscompares++; $display("FAIL reset_rx: got %h expected 00000100", bus.rd_data); end
    @(negedge clk);
    reset = 1'b0;
    bus_read(SPI_REG_CTRL, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL reset_ctrl: got %h expected 0", d); end
  endtask

  task automatic test_ss_and_decode;
    logic [31:0] d;
    bus_write(SPI_REG_SS, 32'h0000_00A5);
    vectors++; if (spi_ss_n !== 8'hA5) begin miscompares++; $display("FAIL ss_pins: got %h expected a5", spi_ss_n); end
    bus_read(SPI_REG_SS, d);
    vectors++; if (d !== 32'hA5) begin miscompares++; $display("FAIL ss_read: got %h expected a5", d); end
    bus_write(5'd5, 32'hFFFF_FFFF);
    bus_read(5'd5, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL unmapped5: got %h expected 0", d); end
    bus_read(5'd31, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL unmapped31: got %h expected 0", d); end
  endtask

  task automatic test_mode0;
    logic [31:0] d;
    int n, c0;
    loop_en = 1'b1;
    bus_write(SPI_REG_CTRL, 32'h0000_0003);
    c0 = cap_n;
    cap_en = 1'b1;
    bus_write(SPI_REG_TX, 32'h0000_00A5);
    vectors++; if (bus.rd_data[8] !== 1'b0) begin miscompares++; $display("FAIL mode0_ready_low: got %b expected 0", bus.rd_data[8]); end
    vectors++; if (spi_mosi !== 1'b1) begin miscompares++; $display("FAIL mode0_first_mosi: got %b expected 1", spi_mosi); end
    wait_ready(n);
    cap_en = 1'b0;
    vectors++; if (n != 64) begin miscompares++; $display("FAIL mode0_busy: got %0d expected 64", n); end
    vectors++; if (cap_n - c0 != 8 || cap !== 8'hA5) begin miscompares++; $display("FAIL mode0_mosi_seq: got %h (%0d bits) expected a5 (8 bits)", cap, cap_n - c0); end
    bus_read(SPI_REG_RX, d);
    vectors++; if (d !== 32'h1A5) begin miscompares++; $display("FAIL mode0_rx: got %h expected 000001a5", d); end
    bus_read(SPI_REG_TX, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL tx_read: got %h expected 0", d); end
    loop_en = 1'b0;
  endtask

  task automatic test_mode3;
    logic [31:0] d;
    int n;
    bus_write(SPI_REG_CTRL, 32'h0003_0000);
    @(negedge clk);
    #1;
    vectors++; if (spi_sclk !== 1'b1) begin miscompares++; $display("FAIL mode3_idle_sclk: got %b expected 1", spi_sclk); end
    slv_byte = 8'h3C;
    slv_en = 1'b1;
    bus_write(SPI_REG_TX, 32'h0000_00C3);
    wait_ready(n);
    slv_en = 1'b0;
    vectors++; if (n != 17) begin miscompares++; $display("FAIL mode3_busy: got %0d expected 17", n); end
    bus_read(SPI_REG_RX, d);
    vectors++; if (d !== 32'h13C) begin miscompares++; $display("FAIL mode3_rx: got %h expected 0000013c", d); end
    vectors++; if (spi_sclk !== 1'b1) begin miscompares++; $display("FAIL mode3_end_sclk: got %b expected 1", spi_sclk); end
  endtask

  task automatic test_tx_while_busy;
    logic [31:0] d;
    int n, c0;
    loop_en = 1'b1;
    bus_write(SPI_REG_CTRL, 32'h0000_0003);
    c0 = cap_n;
    cap_en = 1'b1;
    bus_write(SPI_REG_TX, 32'h0000_0011);
    bus_write(SPI_REG_TX, 32'h0000_0022);
    wait_ready(n);
    cap_en = 1'b0;
    vectors++; if (n != 62) begin miscompares++; $display("FAIL busy_remaining: got %0d expected 62", n); end
    vectors++; if (cap_n - c0 != 8 || cap !== 8'h11) begin miscompares++; $display("FAIL busy_mosi_seq: got %h (%0d bits) expected 11 (8 bits)", cap, cap_n - c0); end
    bus_read(SPI_REG_RX, d);
    vectors++; if (d !== 32'h111) begin miscompares++; $display("FAIL busy_rx: got %h expected 00000111", d); end
    loop_en = 1'b0;
  endtask

  task automatic test_tx_last_cycle;
    logic [31:0] d;
    loop_en = 1'b1;
    bus_write(SPI_REG_CTRL, 32'h0000_0000);
    bus_write(SPI_REG_TX, 32'h0000_0081);
    repeat (14) @(negedge clk);
    bus_write(SPI_REG_TX, 32'h0000_007E);
    vectors++; if (bus.rd_data[8] !== 1'b1) begin miscompares++; $display("FAIL last_cycle_ready: got %b expected 1", bus.rd_data[8]); end
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (bus.rd_data[8] !== 1'b1) begin miscompares++; $display("FAIL last_cycle_no_start: got %b expected 1", bus.rd_data[8]); end
    bus_read(SPI_REG_RX, d);
    vectors++; if (d !== 32'h181) begin miscompares++; $display("FAIL last_cycle_rx: got %h expected 00000181", d); end
    loop_en = 1'b0;
  endtask

  task automatic test_ctrl_mid_transfer;
    logic [31:0] d;
    int n;
    loop_en = 1'b1;
    bus_write(SPI_REG_CTRL, 32'h0000_0001);
    bus_write(SPI_REG_TX, 32'h0000_003C);
    bus_write(SPI_REG_CTRL, 32'h0000_0007);
    wait_ready(n);
    vectors++; if (n != 30) begin miscompares++; $display("FAIL ctrl_mid_busy: got %0d expected 30", n); end
    bus_read(SPI_REG_CTRL, d);
    vectors++; if (d !== 32'h7) begin miscompares++; $display("FAIL ctrl_readback: got %h expected 7", d); end
    bus_write(SPI_REG_TX, 32'h0000_0096);
    wait_ready(n);
    vectors++; if (n != 128) begin miscompares++; $display("FAIL ctrl_next_busy: got %0d expected 128", n); end
    bus_read(SPI_REG_RX, d);
    vectors++; if (d !== 32'h196) begin miscompares++; $display("FAIL ctrl_next_rx: got %h expected 00000196", d); end
    loop_en = 1'b0;
  endtask

  task automatic test_irq;
    logic [31:0] d;
    int n;
    loop_en = 1'b1;
    bus_write(SPI_REG_CTRL, 32'h0000_0000);
`ifdef SPI_IRQ_EN
    bus_write(SPI_REG_IRQ, 32'h0000_0003);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_armed_idle: got %b expected 0", irq); end
    bus_read(SPI_REG_IRQ, d);
    vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL irq_reg_armed: got %h expected 1", d); end
    bus_write(SPI_REG_TX, 32'h0000_0042);
    wait_ready(n);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_after_done: got %b expected 1", irq); end
    bus_read(SPI_REG_IRQ, d);
    vectors++; if (d !== 32'h3) begin miscompares++; $display("FAIL irq_reg_done: got %h expected 3", d); end
    bus_write(SPI_REG_IRQ, 32'h0000_0003);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear: got %b expected 0", irq); end
    bus_write(SPI_REG_TX, 32'h0000_0024);
    repeat (14) @(negedge clk);
    bus_write(SPI_REG_IRQ, 32'h0000_0003);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_set_wins: got %b expected 1", irq); end
    bus_read(SPI_REG_IRQ, d);
    vectors++; if (d !== 32'h3) begin miscompares++; $display("FAIL irq_reg_set_wins: got %h expected 3", d); end
    bus_write(SPI_REG_IRQ, 32'h0000_0002);
    bus_read(SPI_REG_IRQ, d);
    vectors++; if (d !== 32'h0 || irq !== 1'b0) begin miscompares++; $display("FAIL irq_disable: got reg %h irq %b expected 0 0", d, irq); end
`else
    bus_write(SPI_REG_IRQ, 32'h0000_0003);
    bus_read(SPI_REG_IRQ, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL irq_reg_absent: got %h expected 0", d); end
    bus_write(SPI_REG_TX, 32'h0000_0042);
    wait_ready(n);
    vectors++; if (n != 16) begin miscompares++; $display("FAIL irq_xfer_busy: got %0d expected 16", n); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_tied_low: got %b expected 0", irq); end
`endif
    loop_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    bus_write(SPI_REG_SS, 32'h0000_007F);
    bus_write(SPI_REG_CTRL, 32'h0001_0003);
    bus_write(SPI_REG_TX, 32'h0000_005A);
    repeat (20) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (spi_ss_n !== 8'hFF) begin miscompares++; $display("FAIL mid_reset_ss: got %h expected ff", spi_ss_n); end
    vectors++; if (spi_sclk !== 1'b0) begin miscompares++; $display("FAIL mid_reset_sclk: got %b expected 0", spi_sclk); end
    vectors++; if (spi_mosi !== 1'b0) begin miscompares++; $display("FAIL mid_reset_mosi: got %b expected 0", spi_mosi); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL mid_reset_irq: got %b expected 0", irq); end
    vectors++; if (bus.rd_data !== 32'h100) begin miscompares++; $display("FAIL mid_reset_rx: got %h expected 00000100", bus.rd_data); end
    @(negedge clk);
    reset = 1'b0;
    bus_read(SPI_REG_SS, d);
    vectors++; if (d !== 32'hFF) begin miscompares++; $display("FAIL mid_reset_ss_reg: got %h expected ff", d); end
    bus_read(SPI_REG_RX, d);
    vectors++; if (d !== 32'h100) begin miscompares++; $display("FAIL post_reset_rx: got %h expected 00000100", d); end
  endtask

  initial begin
    bus.cs = 1'b0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.addr = SPI_REG_RX;
    bus.wr_data = '0;
    reset = 1'b1;
    test_reset();
    test_ss_and_decode();
    test_mode0();
    test_mode3();
    test_tx_while_busy();
    test_tx_last_cycle();
    test_ctrl_mid_transfer();
    test_irq();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
